// File: rtl/adc_sar_control.sv
// SAR sequencer for the 12-bit capacitor-array ADC: sample, settle, compare per bit,
// then hand the finished code to the back-end over a valid/ready handshake.
module adc_sar_control #(
   parameter int SAMPLE_CYCLES = 2,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        start_in,
   input  logic        comp_in,
   output logic        sample_out,
   output logic [11:0] dac_code_out,
   output logic        comp_latch_out,
   output logic [11:0] result_out,
   output logic        result_valid_out,
   input  logic        result_ready_in,
   output logic        busy_out,
   output logic        overrun_out
);

   typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_SETTLE, S_COMPARE} state_t;

   localparam logic [15:0] SMP_LAST = 16'(SAMPLE_CYCLES - 1);
   localparam logic [15:0] STL_LAST = 16'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   // With no settle time each bit goes straight from the previous compare to the next.
   localparam state_t      S_POST   = (SETTLE_CYCLES == 0) ? S_COMPARE : S_SETTLE;

   state_t      r_state, w_state;
   logic [15:0] r_cnt, w_cnt;
   logic [11:0] r_sar, w_sar;
   logic [3:0]  r_k, w_k;
   logic [11:0] r_result, w_result;
   logic        r_valid, w_valid;
   logic        r_ovr, w_ovr;
   logic        w_consume;
   logic        w_done;
   logic [11:0] w_sar_fin;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_sar    <= '0;
         r_k      <= '0;
         r_result <= '0;
         r_valid  <= 1'b0;
         r_ovr    <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_cnt    <= w_cnt;
         r_sar    <= w_sar;
         r_k      <= w_k;
         r_result <= w_result;
         r_valid  <= w_valid;
         r_ovr    <= w_ovr;
      end
   end

   always_comb begin
      w_state   = r_state;
      w_cnt     = r_cnt;
      w_sar     = r_sar;
      w_k       = r_k;
      w_result  = r_result;
      w_valid   = r_valid;
      w_ovr     = r_ovr;
      w_done    = 1'b0;
      w_consume = r_valid & result_ready_in;
      w_sar_fin = r_sar;
      w_sar_fin[r_k] = comp_in;

      case (r_state)
         S_IDLE: begin
            if (start_in) begin
               w_state = S_SAMPLE;
               w_cnt   = '0;
               w_sar   = '0;
            end
         end
         S_SAMPLE: begin
            if (r_cnt == SMP_LAST) begin
               w_state = S_POST;
               w_cnt   = '0;
               w_k     = 4'd11;
            end else begin
               w_cnt = r_cnt + 16'd1;
            end
         end
         S_SETTLE: begin
            if (r_cnt == STL_LAST) begin
               w_state = S_COMPARE;
               w_cnt   = '0;
            end else begin
               w_cnt = r_cnt + 16'd1;
            end
         end
         S_COMPARE: begin
            w_sar = w_sar_fin;
            if (r_k != 4'd0) begin
               w_k     = r_k - 4'd1;
               w_state = S_POST;
               w_cnt   = '0;
            end else begin
               w_done = 1'b1;
               w_cnt  = '0;
               if (start_in) begin
                  w_state = S_SAMPLE;
                  w_sar   = '0;
               end else begin
                  w_state = S_IDLE;
               end
            end
         end
         default: w_state = S_IDLE;
      endcase

      // A completion on the same edge as a consume is a clean hand-over, not an overrun.
      if (w_consume) begin
         w_valid = 1'b0;
         w_ovr   = 1'b0;
      end
      if (w_done) begin
         w_result = w_sar_fin;
         w_valid  = 1'b1;
         if (r_valid && !w_consume) w_ovr = 1'b1;
      end
   end

   assign sample_out       = (r_state == S_SAMPLE);
   assign comp_latch_out   = (r_state == S_COMPARE);
   assign busy_out         = (r_state != S_IDLE);
   assign dac_code_out     = ((r_state == S_SETTLE) || (r_state == S_COMPARE)) ?
                             (r_sar | (12'd1 << r_k)) : 12'd0;
   assign result_out       = r_result;
   assign result_valid_out = r_valid;
   assign overrun_out      = r_ovr;

endmodule

// File: tb/tb_adc_sar_control.sv
// Directed + randomized checks of adc_sar_control against a binary-search reference.
module tb_adc_sar_control;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, ready, sel;
   logic [11:0] vin;
   int          total = 0;
   int          bad = 0;

   logic        start0, comp0, sample0, latch0, valid0, busy0, ovr0;
   logic [11:0] dac0, res0;
   logic        start1, comp1, sample1, latch1, valid1, busy1, ovr1;
   logic [11:0] dac1, res1;

   assign start0 = start & ~sel;
   assign start1 = start & sel;
   assign comp0  = (vin >= dac0);
   assign comp1  = (vin >= dac1);

   adc_sar_control u_def (
      .clk_in(clk), .rst_n_in(rst_n), .start_in(start0), .comp_in(comp0),
      .sample_out(sample0), .dac_code_out(dac0), .comp_latch_out(latch0),
      .result_out(res0), .result_valid_out(valid0), .result_ready_in(ready),
      .busy_out(busy0), .overrun_out(ovr0));

   adc_sar_control #(.SAMPLE_CYCLES(1), .SETTLE_CYCLES(0)) u_fast (
      .clk_in(clk), .rst_n_in(rst_n), .start_in(start1), .comp_in(comp1),
      .sample_out(sample1), .dac_code_out(dac1), .comp_latch_out(latch1),
      .result_out(res1), .result_valid_out(valid1), .result_ready_in(ready & sel),
      .busy_out(busy1), .overrun_out(ovr1));

   logic        m_sample, m_latch, m_valid, m_busy, m_ovr;
   logic [11:0] m_dac, m_res;
   assign m_sample = sel ? sample1 : sample0;
   assign m_latch  = sel ? latch1  : latch0;
   assign m_valid  = sel ? valid1  : valid0;
   assign m_busy   = sel ? busy1   : busy0;
   assign m_ovr    = sel ? ovr1    : ovr0;
   assign m_dac    = sel ? dac1    : dac0;
   assign m_res    = sel ? res1    : res0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs until the 12th compare has closed, then checks timing and the result
   // against a plain binary search for v.
   task automatic wait_result(input logic [11:0] v, input logic hold);
      int          sc, st, lat, ns, nl, nset, nidle;
      logic [11:0] obs[12];
      logic [11:0] code, trial;
      sc = sel ? 1 : 2;
      st = sel ? 0 : 1;
      lat = 0; ns = 0; nl = 0; nset = 0; nidle = 0;
      for (int i = 0; i < 12; i++) obs[i] = '0;
      do begin
         if (m_sample) ns++;
         if (!m_busy) nidle++;
         if (m_busy && !m_sample && !m_latch) nset++;
         if (m_latch) begin
            if (nl < 12) obs[nl] = m_dac;
            nl++;
         end
         step();
         lat++;
      end while (nl < 12 && lat < 80);
      chk("latency", lat, sc + 12 * (st + 1));
      chk("valid_rise", m_valid, 1'b1);
      chk("result", m_res, v);
      chk("sample_cycles", ns, sc);
      chk("settle_cycles", nset, 12 * st);
      if (hold) chk("busy_gap", nidle, 0);
      code = '0;
      for (int k = 11; k >= 0; k--) begin
         trial = code | (12'd1 << k);
         chk("trial_code", obs[11 - k], trial);
         if (v >= trial) code = trial;
      end
   endtask

   task automatic conv(input logic [11:0] v);
      vin = v;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_result(v, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; ready = 1'b1; sel = 1'b0; vin = '0;
      step(); step();
      chk("rst_sample", m_sample, 0);
      chk("rst_dac", m_dac, 0);
      chk("rst_latch", m_latch, 0);
      chk("rst_result", m_res, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_busy", m_busy, 0);
      chk("rst_ovr", m_ovr, 0);
      rst_n = 1'b1;
      step();

      conv(12'hA5C);
      step();
      chk("consumed", m_valid, 0);
      conv(12'h000);
      conv(12'hFFF);
      repeat (4) conv(12'($urandom_range(0, 4095)));
      step();

      // back-to-back with start held
      vin = 12'h123; start = 1'b1;
      step();
      wait_result(12'h123, 1'b1);
      for (int i = 1; i < 4; i++) begin
         vin = (i % 2) ? 12'hEDC : 12'h123;
         wait_result(vin, 1'b1);
      end
      start = 1'b0;
      vin = 12'h321;
      wait_result(12'h321, 1'b1);
      step(); step();
      chk("idle_after_b2b", m_busy, 0);

      // overrun
      ready = 1'b0; start = 1'b1; vin = 12'h111;
      step();
      wait_result(12'h111, 1'b1);
      chk("no_ovr_yet", m_ovr, 0);
      start = 1'b0; vin = 12'h222;
      wait_result(12'h222, 1'b1);
      chk("ovr_set", m_ovr, 1);
      repeat (3) step();
      chk("result_stable", m_res, 12'h222);
      chk("valid_held", m_valid, 1);
      ready = 1'b1;
      step();
      chk("ovr_consume_valid", m_valid, 0);
      chk("ovr_cleared", m_ovr, 0);

      // reset mid-conversion with a result pending
      ready = 1'b0;
      conv(12'h3C3);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (9) step();
      chk("midconv_busy", m_busy, 1);
      rst_n = 1'b0;
      #2;
      chk("arst_valid", m_valid, 0);
      chk("arst_busy", m_busy, 0);
      chk("arst_dac", m_dac, 0);
      chk("arst_sample", m_sample, 0);
      chk("arst_latch", m_latch, 0);
      chk("arst_result", m_res, 0);
      chk("arst_ovr", m_ovr, 0);
      rst_n = 1'b1;
      ready = 1'b1;
      step();
      conv(12'h6B9);
      step();

      // fast instance: one sample cycle, no settle
      sel = 1'b1;
      step();
      conv(12'h5A5);
      conv(12'($urandom_range(0, 4095)));
      step();
      chk("fast_consumed", m_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adc_sar_control.md
Name: adc_sar_control

Overview:
Successive-approximation controller for the 12-bit SAR ADC. It sits directly upstream of the capacitor-array row/column decoder. It drives the 12-bit trial code that the decoder turns into row/column/bincap switch controls, and it sequences the sample, settle and compare phases. It resolves one bit per compare from the comparator decision and hands each finished conversion to the digital back-end over a valid/ready handshake.

Parameters:
SAMPLE_CYCLES, 2, cycles sample_out is held high per conversion; legal range >= 1
SETTLE_CYCLES, 1, DAC settle cycles before each compare strobe; legal range >= 0

Ports:
clk_in  input  1  single clock, rising edge
rst_n_in  input  1  reset; asynchronous assert, active-low
start_in  input  1  conversion request, level-sensitive; sampled only in IDLE and at end of conversion
comp_in  input  1  comparator decision; 1 = Vin >= Vdac (keep trial bit); valid in the cycle comp_latch_out=1
sample_out  output  1  high while input is sampled onto the array
dac_code_out  output  12  trial code to the row/col decoder data input ([11:8] row, [7:3] col, [2:0] bincap)
comp_latch_out  output  1  comparator strobe, one cycle per bit
result_out  output  12  last completed conversion
result_valid_out  output  1  result_out holds unconsumed data
result_ready_in  input  1  consumer accepts result when high together with valid
busy_out  output  1  high in every state except IDLE
overrun_out  output  1  sticky: an unconsumed result was overwritten

Behaviour:
- Reset (async, rst_n_in=0):
  - State IDLE.
  - sample_out, comp_latch_out, result_valid_out, busy_out and overrun_out all 0.
  - dac_code_out, result_out, the internal SAR register and the bit index all 0.
- Reset asserted mid-conversion:
  - Partial conversion is discarded.
  - A pending result is dropped (valid falls immediately).
- States: IDLE, SAMPLE, SETTLE, COMPARE.
- IDLE:
  - dac_code_out = 0.
  - If start_in=1 at a clock edge, go to SAMPLE and clear the SAR register.
- SAMPLE:
  - sample_out=1 and dac_code_out=0 for exactly SAMPLE_CYCLES cycles.
  - Then set bit index k=11 and go to SETTLE, or to COMPARE if SETTLE_CYCLES=0.
- Trial code: dac_code_out = SAR | (1<<k). It is presented from the first SETTLE cycle through the COMPARE cycle of bit k.
- SETTLE:
  - Lasts SETTLE_CYCLES cycles.
  - comp_latch_out=0.
- COMPARE:
  - Lasts one cycle with comp_latch_out=1.
  - comp_in is captured at the closing edge: SAR[k] = comp_in; lower bits stay 0.
  - If k>0: decrement k and go to SETTLE (or COMPARE if SETTLE_CYCLES=0).
  - If k=0: conversion completes (see below).
- Conversion complete, at the closing edge of COMPARE with k=0:
  - result_out = final SAR including bit 0; result_valid_out=1.
  - Next state is SAMPLE if start_in=1 (back-to-back, no IDLE cycle), else IDLE.
- Latency, from the edge that accepts start to the edge raising result_valid_out: SAMPLE_CYCLES + 12*(SETTLE_CYCLES+1) cycles. With defaults this is 26; back-to-back period is also 26.
- Handshake:
  - A result is consumed at an edge where result_valid_out=1 and result_ready_in=1; valid clears at that edge unless a new result loads at the same edge.
  - result_out is stable while valid=1 and not consumed.
  - If completion coincides with a consuming edge, the new result loads, valid stays 1 and there is no overrun.
- Overrun:
  - Completion while valid=1 and not consumed overwrites result_out and sets overrun_out=1.
  - overrun_out clears on the next consuming edge; it is not cleared by start.
- start_in is ignored while busy, except at conversion completion.
- SAR arithmetic is pure bit set/clear; no carries and no wrap.

Test Plan:
- Comparator model comp_in = (0xA5C >= dac_code_out); pulse start_in one cycle; ready=1. Required:
  - Trial codes in order 0x800, 0xC00, 0xA00, 0xB00, 0xA80, 0xA40, 0xA60, 0xA50, 0xA58, 0xA5C, 0xA5E, 0xA5D.
  - result_out=0xA5C with valid rising exactly 26 cycles after start.
  - sample_out high 2 cycles; 12 single-cycle comp_latch_out pulses.
- Boundary inputs: Vin=0x000 -> result 0x000; Vin=0xFFF -> result 0xFFF; both at 26-cycle latency.
- start_in held high with ready=1 and Vin alternating 0x123 / 0xEDC -> results 0x123, 0xEDC every 26 cycles, busy_out never low between conversions.
- ready=0 across two back-to-back conversions (0x111 then 0x222) -> result_out=0x222, overrun_out=1. Then ready=1 for one cycle -> valid=0 and overrun_out=0 on that edge.
- rst_n_in low for one cycle at cycle 10 of a conversion (no clock edge needed) -> all outputs 0 immediately. A new start then yields a correct result with full 26-cycle latency.
- Parameters SAMPLE_CYCLES=1, SETTLE_CYCLES=0, Vin=0x5A5 -> result 0x5A5 after 13 cycles, comp_latch_out high every cycle after sampling.
